// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core: opcode map, fetch FSM encoding and
// the operand-length helper used by fetch and decode.
package risc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDO = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STO = 4'h3;
  localparam logic [3:0] OP_PRE = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_LDM = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;

  typedef enum logic [1:0] {
    ST_FETCH_OP  = 2'd0,
    ST_FETCH_ARG = 2'd1,
    ST_HOLD      = 2'd2,
    ST_HALT      = 2'd3
  } fetch_state_e;

  // Only the memory-access opcodes carry an operand byte; undefined opcodes are single-byte.
  function automatic logic has_operand(input logic [3:0] op);
    logic res;
    case (op)
      OP_LDO, OP_LDA, OP_STO: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: async clear, synchronous load of a redirect target, and
// a wrapping increment.
module pc_counter import risc_pkg::*; #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_r;

  // Load beats increment so a redirect never advances past its target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= {AW{1'b0}};
    end else if (load) begin
      pc_r <= load_addr;
    end else if (inc) begin
      pc_r <= pc_r + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: walks the program ROM, assembles one/two-byte instructions and
// hands them to the decoder over valid/ready; honours redirects and HLT.
module instr_fetch import risc_pkg::*; #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] rom_addr,
  output logic          rom_read,
  output logic          rom_ena,
  output logic [DW-1:0] ir_op,
  output logic [DW-1:0] ir_arg,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  output logic          halted
);

  fetch_state_e  state_r;
  logic [AW-1:0] pc_s;
  logic [DW-1:0] ir_op_r;
  logic [DW-1:0] ir_arg_r;
  logic [AW-1:0] ir_pc_r;
  logic          fetching_s;
  logic          pc_inc_s;

  assign fetching_s = (state_r == ST_FETCH_OP) || (state_r == ST_FETCH_ARG);
  assign pc_inc_s   = fetching_s && !jmp_en;

  pc_counter #(.AW(AW)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (jmp_en),
    .load_addr (jmp_addr),
    .inc       (pc_inc_s),
    .pc        (pc_s)
  );

  // Fetch FSM and instruction register; a redirect overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_FETCH_OP;
      ir_op_r  <= {DW{1'b0}};
      ir_arg_r <= {DW{1'b0}};
      ir_pc_r  <= {AW{1'b0}};
    end else if (jmp_en) begin
      state_r  <= ST_FETCH_OP;
    end else begin
      case (state_r)
        ST_FETCH_OP: begin
          ir_op_r <= rom_data;
          ir_pc_r <= pc_s;
          if (has_operand(rom_data[DW-1 -: 4])) begin
            state_r <= ST_FETCH_ARG;
          end else begin
            ir_arg_r <= {DW{1'b0}};
            state_r  <= ST_HOLD;
          end
        end
        ST_FETCH_ARG: begin
          ir_arg_r <= rom_data;
          state_r  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ir_ready) begin
            state_r <= (ir_op_r[DW-1 -: 4] == OP_HLT) ? ST_HALT : ST_FETCH_OP;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r <= ST_FETCH_OP;
        end
      endcase
    end
  end

  // Strobes are masked while reset is held so the ROM sees no access then.
  assign rom_read = fetching_s && rst_n;
  assign rom_ena  = rom_read;
  assign rom_addr = pc_s;
  assign ir_op    = ir_op_r;
  assign ir_arg   = ir_arg_r;
  assign ir_pc    = ir_pc_r;
  assign ir_valid = (state_r == ST_HOLD);
  assign halted   = (state_r == ST_HALT);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction fetch stage of the RISC core; sits between the program ROM and the instruction decoder.
- Holds the program counter and drives the ROM's `addr`/`read`/`ena`; the ROM returns data combinationally.
- Assembles one- and two-byte instructions (opcode byte plus optional operand byte) and presents each to the decoder over a valid/ready handshake.
- Also handles jump redirects from the core and stops fetching after HLT.

## Interface
Parameters:
- `AW`, 8: ROM address width; the PC wraps modulo 2^AW.
- `DW`, 8: instruction byte width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rom_data` in DW: ROM data output; sampled only in fetch states.
- `rom_addr` out AW: ROM address; always equals `pc`.
- `rom_read` out 1: ROM read strobe.
- `rom_ena` out 1: ROM enable; equal to `rom_read`.
- `ir_op` out DW: opcode byte, `[7:4]` opcode and `[3:0]` register field.
- `ir_arg` out DW: operand byte; 0 for one-byte instructions.
- `ir_pc` out AW: address of the opcode byte.
- `ir_valid` out 1: instruction available to the decoder.
- `ir_ready` in 1: decoder accepts the instruction.
- `jmp_en` in 1: one-cycle redirect request.
- `jmp_addr` in AW: redirect target.
- `halted` out 1: HLT accepted; fetch stopped.

## Operation
Four-state Moore FSM: `FETCH_OP`, `FETCH_ARG`, `HOLD`, `HALT`.

- **Strobes.** `rom_read` and `rom_ena` are 1 only in `FETCH_OP` and `FETCH_ARG`, and 0 otherwise.
- **FETCH_OP.** On the edge, latch `rom_data` into `ir_op` and `pc` into `ir_pc`, then `pc <= pc+1`.
  - If opcode is LDO (0001), LDA (0010) or STO (0011), go to `FETCH_ARG`.
  - Otherwise clear `ir_arg` and go to `HOLD`.
- **FETCH_ARG.** Latch `rom_data` into `ir_arg`, `pc <= pc+1`, go to `HOLD`.
- **HOLD.** `ir_valid` = 1; `pc` and outputs are frozen.
  - On `ir_ready`=1 the handshake completes at that edge.
  - If `ir_op[7:4]` is HLT (0111), go to `HALT`; otherwise go to `FETCH_OP`.
- **HALT.** `halted` = 1 and no ROM access. Leave only through `jmp_en` or reset.
- **Redirect.** `jmp_en` = 1 in any state has top priority.
  - `pc <= jmp_addr`, `ir_valid` drops, `halted` clears, next state is `FETCH_OP`.
  - A partially fetched instruction (in `FETCH_ARG`) is discarded.
  - If `jmp_en` and `ir_ready` are both 1 in `HOLD`, the held instruction counts as consumed. The redirect still wins, so a held HLT does not enter `HALT`.
- **Wrap-around.** The PC increment is modulo 2^AW, so 0xFF+1 = 0x00. An operand byte at 0x00 after an opcode at 0xFF is legal.
- **Opcodes.** All opcodes other than the three two-byte ones are single-byte, including undefined ones. They are passed through unchanged.

## Timing
- **Reset values:** `pc`=0, `rom_addr`=0, `rom_read`=0, `rom_ena`=0, `ir_op`=0, `ir_arg`=0, `ir_pc`=0, `ir_valid`=0, `halted`=0; state `FETCH_OP`.
  - Assertion of `rst_n` clears everything immediately, mid-fetch or mid-hold.
- **Strobes after reset:** in `FETCH_OP` immediately after reset, strobes read 1 combinationally. The first sampling edge after deassertion fetches address 0.
- **Latency**, opcode edge = cycle N:
  - One-byte instruction: `ir_valid` high in cycle N+1.
  - Two-byte instruction: `ir_valid` high in cycle N+2.
- **Throughput** with `ir_ready` held at 1: one-byte instructions every 2 cycles, two-byte every 3.
- **Backpressure:** while `ir_ready`=0, the outputs remain stable indefinitely and no ROM access occurs.
- **Redirect timing:** `jmp_en` sampled at edge E gives `rom_addr` = `jmp_addr` in cycle E+1, and the new opcode is latched at edge E+1.
- **Halt timing:** `halted` rises the cycle after the HLT handshake.

## Structure
- **Shared package `risc_pkg`:**
  - 4-bit opcode constants: NOP, LDO, LDA, STO, PRE, ADD, LDM, HLT, AND, OR, XOR, SUB, INC, DEC.
  - Fetch state encoding.
  - Function `has_operand(op)`.
  - The decoder uses the same package.
- **Sub-module `pc_counter`:** AW-bit register with synchronous load (`jmp_addr`), increment-enable and async active-low clear.
- Everything else lives in `instr_fetch`.

## Test plan
- **Reset release with ROM[0]=0x00, `ir_ready`=1:** `rom_addr` 0 is read; `ir_valid` high 1 cycle after the fetch edge with `ir_op`=0x00, `ir_arg`=0x00, `ir_pc`=0. The next fetch is at address 1.
- **ROM[1]=0x11, ROM[2]=0x61:** `ir_op`=0x11, `ir_arg`=0x61, `ir_pc`=1; valid 2 cycles after the opcode edge. The next fetch is at address 3.
- **`ir_ready`=0 for 5 cycles on instruction 0x45 at pc 7:** `ir_valid` stays 1, outputs and `rom_addr`=8 are stable, `rom_read`=0 throughout. Release, then the next fetch is at 8.
- **`jmp_en` with `jmp_addr`=0x20 during `FETCH_ARG` of 0x31 at pc 10:** the partial instruction is dropped. The next `ir_pc`=0x20 and no instruction with `ir_pc`=10 is issued.
- **HLT 0x70 at pc 40 accepted:** `halted`=1 from the next cycle and `rom_read`=0 for 20 cycles. Then `jmp_en` to 0 clears `halted` and fetch resumes at 0.
- **Jump to 0xFF with ROM[0xFF]=0x12, ROM[0x00]=0x05:** `ir_op`=0x12, `ir_arg`=0x05, `ir_pc`=0xFF; the next fetch is at address 0x01.
